// File: rtl/sd_resp_rx_pkg.sv
// Purpose: constants shared by the slave response transmitter and the
//          master-side response receiver (marker byte, payload cap, STATUS
//          bit positions) plus the receiver state type.
// Ports:   none (package).
package sd_resp_rx_pkg;

  // Start-of-message byte sent by the slave.
  localparam logic [7:0] MARKER_SLAVE = 8'hA5;

  // Largest legal data-phase payload in bytes.
  localparam int unsigned S_DP_LEN = 256;

  // STATUS byte bit positions; bits 3 and 5-7 are reserved.
  localparam int unsigned ERROR_IN_MSG = 0;
  localparam int unsigned SERVICE_REQ  = 1;
  localparam int unsigned SD_BUSY      = 2;
  localparam int unsigned DP_SENDING   = 4;

  // Receiver parse position within a frame.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STATUS  = 3'd1,
    ST_N1      = 3'd2,
    ST_N2      = 3'd3,
    ST_PAYLOAD = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sd_rx_tmo.sv
// Purpose: inter-byte timeout counter for the response receiver.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous, active-high reset
//   en       in  count enable (receiver is mid-message)
//   kick     in  byte received this cycle; restarts the count
//   expire_c out combinational: the count reaches TMO_CYCLES-1 on this edge
module sd_rx_tmo #(
  parameter int unsigned TMO_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  output logic expire_c
);

  // Holds values up to TMO_CYCLES-1.
  localparam int unsigned CW = $clog2(TMO_CYCLES);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CW'(1);

  // Expiry is evaluated on the incremented value so the owner can react on
  // the same edge; a byte arriving on that edge wins over the timeout.
  assign expire_c = en && !kick && (w_cnt_inc == CW'(TMO_CYCLES - 1));

  // Cycles since the last received byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (kick || !en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/sd_resp_rx.sv
// Purpose: master-side parser for slave response frames
//          (MARKER, STATUS, N1, N2, N payload bytes).
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   d          in   received byte
//   d_rdy      in   one-cycle strobe, d valid
//   status     out  latched STATUS byte
//   status_vld out  pulse when status is updated
//   pl_len     out  latched {N1,N2}
//   pl_d       out  payload byte
//   pl_d_vld   out  pulse per payload byte
//   msg_end    out  pulse, message received without error
//   err_marker out  pulse, non-marker byte seen while idle
//   err_len    out  pulse, illegal length field
//   err_tmo    out  pulse, inter-byte timeout
//   busy       out  high whenever a message is in progress
module sd_resp_rx
  import sd_resp_rx_pkg::*;
#(
  parameter logic [7:0]  MARKER     = MARKER_SLAVE,
  parameter int unsigned MAX_LEN    = S_DP_LEN,
  parameter int unsigned TMO_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  d,
  input  logic        d_rdy,
  output logic [7:0]  status,
  output logic        status_vld,
  output logic [15:0] pl_len,
  output logic [7:0]  pl_d,
  output logic        pl_d_vld,
  output logic        msg_end,
  output logic        err_marker,
  output logic        err_len,
  output logic        err_tmo,
  output logic        busy
);

  rx_state_t   r_state,      w_state_nx;
  logic [7:0]  r_status,     w_status_nx;
  logic [15:0] r_pl_len,     w_pl_len_nx;
  logic [7:0]  r_pl_d,       w_pl_d_nx;
  logic [15:0] r_cnt,        w_cnt_nx;
  logic        r_status_vld, w_status_vld_nx;
  logic        r_pl_d_vld,   w_pl_d_vld_nx;
  logic        r_msg_end,    w_msg_end_nx;
  logic        r_err_marker, w_err_marker_nx;
  logic        r_err_len,    w_err_len_nx;
  logic        r_err_tmo,    w_err_tmo_nx;
  logic        r_busy;

  logic        w_tmo_expire;
  logic [15:0] w_len;
  logic [15:0] w_cnt_inc;

  // Length as it will be once the N2 byte is latched.
  assign w_len     = {r_pl_len[15:8], d};
  assign w_cnt_inc = r_cnt + 16'd1;

  sd_rx_tmo #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .en       (r_state != ST_IDLE),
    .kick     (d_rdy),
    .expire_c (w_tmo_expire)
  );

  // Next-state and next-output decode.
  always_comb begin
    w_state_nx      = r_state;
    w_status_nx     = r_status;
    w_pl_len_nx     = r_pl_len;
    w_pl_d_nx       = r_pl_d;
    w_cnt_nx        = r_cnt;
    w_status_vld_nx = 1'b0;
    w_pl_d_vld_nx   = 1'b0;
    w_msg_end_nx    = 1'b0;
    w_err_marker_nx = 1'b0;
    w_err_len_nx    = 1'b0;
    w_err_tmo_nx    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (d_rdy) begin
          if (d == MARKER) begin
            w_state_nx = ST_STATUS;
          end else begin
            w_err_marker_nx = 1'b1;
          end
        end
      end
      ST_STATUS: begin
        if (d_rdy) begin
          w_status_nx     = d;
          w_status_vld_nx = 1'b1;
          w_state_nx      = ST_N1;
        end
      end
      ST_N1: begin
        if (d_rdy) begin
          w_pl_len_nx[15:8] = d;
          w_state_nx        = ST_N2;
        end
      end
      ST_N2: begin
        if (d_rdy) begin
          w_pl_len_nx[7:0] = d;
          w_state_nx       = ST_IDLE;
          if (!r_status[DP_SENDING]) begin
            // Status-only frame must carry a zero length.
            if (w_len == 16'd0) begin
              w_msg_end_nx = 1'b1;
            end else begin
              w_err_len_nx = 1'b1;
            end
          end else if ((w_len != 16'd0) && (32'(w_len) <= MAX_LEN)) begin
            w_cnt_nx   = 16'd0;
            w_state_nx = ST_PAYLOAD;
          end else begin
            w_err_len_nx = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        // Marker values are plain data here.
        if (d_rdy) begin
          w_pl_d_nx     = d;
          w_pl_d_vld_nx = 1'b1;
          w_cnt_nx      = w_cnt_inc;
          if (w_cnt_inc == r_pl_len) begin
            w_msg_end_nx = 1'b1;
            w_state_nx   = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    // Expiry is already masked by d_rdy and by IDLE inside the counter.
    if (w_tmo_expire) begin
      w_err_tmo_nx = 1'b1;
      w_state_nx   = ST_IDLE;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_status     <= 8'd0;
      r_pl_len     <= 16'd0;
      r_pl_d       <= 8'd0;
      r_cnt        <= 16'd0;
      r_status_vld <= 1'b0;
      r_pl_d_vld   <= 1'b0;
      r_msg_end    <= 1'b0;
      r_err_marker <= 1'b0;
      r_err_len    <= 1'b0;
      r_err_tmo    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_status     <= w_status_nx;
      r_pl_len     <= w_pl_len_nx;
      r_pl_d       <= w_pl_d_nx;
      r_cnt        <= w_cnt_nx;
      r_status_vld <= w_status_vld_nx;
      r_pl_d_vld   <= w_pl_d_vld_nx;
      r_msg_end    <= w_msg_end_nx;
      r_err_marker <= w_err_marker_nx;
      r_err_len    <= w_err_len_nx;
      r_err_tmo    <= w_err_tmo_nx;
      r_busy       <= (w_state_nx != ST_IDLE);
    end
  end

  assign status     = r_status;
  assign status_vld = r_status_vld;
  assign pl_len     = r_pl_len;
  assign pl_d       = r_pl_d;
  assign pl_d_vld   = r_pl_d_vld;
  assign msg_end    = r_msg_end;
  assign err_marker = r_err_marker;
  assign err_len    = r_err_len;
  assign err_tmo    = r_err_tmo;
  assign busy       = r_busy;

endmodule

// File: tb/tb_sd_resp_rx.sv
// Purpose: self-checking bench for sd_resp_rx. A frame-level reference model
//          (byte queue of the message in progress) predicts every output after
//          every clock edge; directed frames are followed by random frames.
module tb_sd_resp_rx;
  import sd_resp_rx_pkg::*;

  localparam int unsigned MAX_LEN    = 4;
  localparam int unsigned TMO_CYCLES = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  d;
  logic        d_rdy;
  logic [7:0]  status;
  logic        status_vld;
  logic [15:0] pl_len;
  logic [7:0]  pl_d;
  logic        pl_d_vld;
  logic        msg_end;
  logic        err_marker;
  logic        err_len;
  logic        err_tmo;
  logic        busy;

  sd_resp_rx #(
    .MARKER     (MARKER_SLAVE),
    .MAX_LEN    (MAX_LEN),
    .TMO_CYCLES (TMO_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .d_rdy      (d_rdy),
    .status     (status),
    .status_vld (status_vld),
    .pl_len     (pl_len),
    .pl_d       (pl_d),
    .pl_d_vld   (pl_d_vld),
    .msg_end    (msg_end),
    .err_marker (err_marker),
    .err_len    (err_len),
    .err_tmo    (err_tmo),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  string step_name = "none";

  // Reference model state: bytes of the message in progress.
  logic [7:0]  m_q[$];
  logic [7:0]  m_status;
  logic [15:0] m_pl_len;
  logic [7:0]  m_pl_d;
  int          m_idle;
  logic e_status_vld, e_pl_d_vld, e_msg_end, e_err_marker, e_err_len, e_err_tmo;

  task automatic model_reset();
    m_q.delete();
    m_status = 8'd0;
    m_pl_len = 16'd0;
    m_pl_d   = 8'd0;
    m_idle   = 0;
    e_status_vld = 1'b0; e_pl_d_vld = 1'b0; e_msg_end = 1'b0;
    e_err_marker = 1'b0; e_err_len  = 1'b0; e_err_tmo = 1'b0;
  endtask

  task automatic clear_pulses();
    e_status_vld = 1'b0; e_pl_d_vld = 1'b0; e_msg_end = 1'b0;
    e_err_marker = 1'b0; e_err_len  = 1'b0; e_err_tmo = 1'b0;
  endtask

  // One received byte: its position in the frame decides its meaning.
  task automatic model_byte(input logic [7:0] b);
    bit legal;
    clear_pulses();
    m_idle = 0;
    if (m_q.size() == 0) begin
      if (b == MARKER_SLAVE) m_q.push_back(b);
      else e_err_marker = 1'b1;
    end else begin
      m_q.push_back(b);
      case (m_q.size())
        2: begin
          m_status     = b;
          e_status_vld = 1'b1;
        end
        3: m_pl_len[15:8] = b;
        4: begin
          m_pl_len[7:0] = b;
          if (m_status[4]) legal = (m_pl_len >= 16'd1) && (int'(m_pl_len) <= int'(MAX_LEN));
          else             legal = (m_pl_len == 16'd0);
          if (!legal) begin
            e_err_len = 1'b1;
            m_q.delete();
          end else if (!m_status[4]) begin
            e_msg_end = 1'b1;
            m_q.delete();
          end
        end
        default: begin
          m_pl_d     = b;
          e_pl_d_vld = 1'b1;
          if (m_q.size() - 4 == int'(m_pl_len)) begin
            e_msg_end = 1'b1;
            m_q.delete();
          end
        end
      endcase
    end
  endtask

  // One clock with no byte: a message in progress times out after
  // TMO_CYCLES-1 silent cycles.
  task automatic model_idle();
    clear_pulses();
    if (m_q.size() != 0) begin
      m_idle++;
      if (m_idle == int'(TMO_CYCLES) - 1) begin
        e_err_tmo = 1'b1;
        m_q.delete();
      end
    end
  endtask

  task automatic check();
    logic [38:0] act;
    logic [38:0] exp;
    act = {status, status_vld, pl_len, pl_d, pl_d_vld, msg_end,
           err_marker, err_len, err_tmo, busy};
    exp = {m_status, e_status_vld, m_pl_len, m_pl_d, e_pl_d_vld, e_msg_end,
           e_err_marker, e_err_len, e_err_tmo, (m_q.size() != 0)};
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: observed={st,sv,len,pd,pv,end,em,el,et,busy}=%h expected=%h",
             step_name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    d     = b;
    d_rdy = 1'b1;
    @(posedge clk);
    #1;
    model_byte(b);
    check();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d_rdy = 1'b0;
      d     = 8'($urandom);
      @(posedge clk);
      #1;
      model_idle();
      check();
    end
  endtask

  task automatic send_frame(input logic [7:0] st, input logic [15:0] len,
                            input int npl, input int gap_mode);
    logic [7:0] hdr[4];
    hdr[0] = MARKER_SLAVE;
    hdr[1] = st;
    hdr[2] = len[15:8];
    hdr[3] = len[7:0];
    for (int i = 0; i < 4 + npl; i++) begin
      if (gap_mode != 0) idle_cycles(pick_gap());
      send_byte(i < 4 ? hdr[i] : 8'($urandom));
    end
  endtask

  // Mostly back-to-back, occasionally right at or past the timeout.
  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 39));
    if (r == 0)       return int'(TMO_CYCLES) - 1;
    else if (r == 1)  return int'(TMO_CYCLES) - 2;
    else if (r < 8)   return int'($urandom_range(1, 3));
    else              return 0;
  endfunction

  task automatic do_reset_now();
    @(negedge clk);
    d_rdy = 1'b0;
    rst   = 1'b1;
    #1;
    model_reset();
    check();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]  st;
    logic [15:0] len;
    int          npl;
    int          r;

    rst   = 1'b1;
    d     = 8'd0;
    d_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step_name = "reset";
    check();
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

    step_name = "status_only";
    send_byte(MARKER_SLAVE); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    idle_cycles(2);

    step_name = "payload4";
    send_byte(MARKER_SLAVE); send_byte(8'h10); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    idle_cycles(2);

    step_name = "len_dp_zero";
    send_byte(MARKER_SLAVE); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    step_name = "len_nodp_nonzero";
    send_byte(MARKER_SLAVE); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
    step_name = "len_over_max";
    send_byte(MARKER_SLAVE); send_byte(8'h10); send_byte(8'h00); send_byte(8'h05);
    step_name = "after_len_err";
    send_byte(MARKER_SLAVE); send_byte(8'h17); send_byte(8'h00); send_byte(8'h02);
    send_byte(MARKER_SLAVE); send_byte(8'h3C);
    idle_cycles(2);

    step_name = "junk_marker";
    send_byte(8'h55);
    send_byte(MARKER_SLAVE); send_byte(8'h06); send_byte(8'h00); send_byte(8'h00);
    idle_cycles(1);

    step_name = "timeout_after_n1";
    send_byte(MARKER_SLAVE); send_byte(8'h10); send_byte(8'h00);
    idle_cycles(int'(TMO_CYCLES));

    step_name = "rdy_on_expiry";
    send_byte(MARKER_SLAVE); send_byte(8'h10);
    idle_cycles(int'(TMO_CYCLES) - 2);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h77);
    idle_cycles(2);

    step_name = "reset_mid_payload";
    send_byte(MARKER_SLAVE); send_byte(8'h10); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22);
    do_reset_now();
    idle_cycles(1);
    step_name = "after_reset";
    send_byte(MARKER_SLAVE); send_byte(8'h12); send_byte(8'h00); send_byte(8'h03);
    send_byte(MARKER_SLAVE); send_byte(8'h00); send_byte(8'hFF);
    idle_cycles(2);

    step_name = "random";
    for (int f = 0; f < 200; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        send_byte(8'($urandom));
      end
      st    = 8'($urandom);
      st[4] = 1'($urandom);
      r     = int'($urandom_range(0, 9));
      if (st[4]) begin
        if (r < 7)       len = 16'($urandom_range(1, MAX_LEN));
        else if (r == 7) len = 16'd0;
        else if (r == 8) len = 16'(MAX_LEN + 1);
        else             len = 16'($urandom);
      end else begin
        len = (r < 7) ? 16'd0 : 16'($urandom_range(1, 300));
      end
      npl = (st[4] && len != 16'd0 && int'(len) <= int'(MAX_LEN)) ? int'(len) : 0;
      send_frame(st, len, npl, int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 49) == 0) do_reset_now();
    end
    idle_cycles(int'(TMO_CYCLES));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
